// File: rtl/quadrature_frontend_if.sv
// Quadrature front-end signal bundle: raw encoder channels and the error-clear
// strobe travel toward the decoder; filtered levels and decode pulses come back.
// There is no valid/ready handshake. The raw channels are asynchronous levels.
// err_clear is a single-cycle strobe sampled on the rising clock edge. step,
// err and index are registered one-clock pulses. dir, err_count, a_f, b_f and
// z_f are registered levels.
interface quadrature_frontend_if;
  logic       A;
  logic       B;
  logic       Z;
  logic       err_clear;
  logic       step;
  logic       dir;
  logic       index;
  logic       err;
  logic [7:0] err_count;
  logic       a_f;
  logic       b_f;
  logic       z_f;

  // Encoder/controller side: drives the raw inputs and consumes decode results.
  modport master (
    output A, B, Z, err_clear,
    input  step, dir, index, err, err_count, a_f, b_f, z_f
  );

  // Decoder side.
  modport slave (
    input  A, B, Z, err_clear,
    output step, dir, index, err, err_count, a_f, b_f, z_f
  );
endinterface

// File: rtl/quadrature_frontend.sv
// Quadrature encoder front end. Each raw channel passes through a 2-flop
// synchronizer and then a mismatch-length glitch filter. The filtered A/B pair
// feeds a 4x decoder that produces step/dir and flags illegal double
// transitions. Filtered Z produces an index pulse that can be gated by A=B=1.
module quadrature_frontend #(
  parameter int unsigned FILTER_LEN = 4,   // 1..15 clocks of sustained mismatch
  parameter bit          INDEX_GATE = 1'b1
) (
  input  logic                  csi_MCLK_clk,
  input  logic                  rsi_MRST_reset_n,
  quadrature_frontend_if.slave  bus
);

  // The filter toggles on the edge that completes FILTER_LEN mismatching edges.
  // When the counter already holds FILTER_LEN-1, the current edge is the last one.
  localparam logic [3:0] LP_LAST = 4'(FILTER_LEN - 1);

  // Channel order in the per-channel vectors: bit 0 = A, bit 1 = B, bit 2 = Z.
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_filt;
  logic [3:0] r_cnt [3];

  logic       r_prev_a;
  logic       r_prev_b;
  logic       r_prev_z;
  logic       r_step;
  logic       r_dir;
  logic       r_index;
  logic       r_err;
  logic [7:0] r_err_count;

  logic       w_a_chg;
  logic       w_b_chg;
  logic       w_legal;
  logic       w_illegal;
  logic       w_fwd;
  logic       w_z_rise;
  logic       w_gate_ok;

  // Two-flop synchronizers for the asynchronous encoder inputs.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {bus.Z, bus.B, bus.A};
      r_sync2 <= r_sync1;
    end
  end

  // Glitch filter: count consecutive mismatching edges, toggle when the run is long enough.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_filt <= '0;
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (r_cnt[i] == LP_LAST) begin
            r_filt[i] <= ~r_filt[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i]  <= r_cnt[i] + 4'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Compare the previous filtered state with the current one.
  // Forward order 00->10->11->01->00 means a single-bit move is forward
  // exactly when the new A differs from the old B.
  assign w_a_chg   = r_filt[0] ^ r_prev_a;
  assign w_b_chg   = r_filt[1] ^ r_prev_b;
  assign w_legal   = w_a_chg ^ w_b_chg;
  assign w_illegal = w_a_chg & w_b_chg;
  assign w_fwd     = r_filt[0] ^ r_prev_b;
  assign w_z_rise  = r_filt[2] & ~r_prev_z;
  assign w_gate_ok = (INDEX_GATE == 1'b0) || (r_filt[0] && r_filt[1]);

  // Decoder: previous-state register, registered pulses, direction and error counter.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      r_prev_a    <= 1'b0;
      r_prev_b    <= 1'b0;
      r_prev_z    <= 1'b0;
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
      r_index     <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_prev_a <= r_filt[0];
      r_prev_b <= r_filt[1];
      r_prev_z <= r_filt[2];
      r_step   <= w_legal;
      r_err    <= w_illegal;
      r_index  <= w_z_rise & w_gate_ok;
      if (w_legal) begin
        r_dir <= w_fwd;
      end
      // A clear wins over a simultaneous error. The count saturates at 255.
      if (bus.err_clear) begin
        r_err_count <= '0;
      end else if (w_illegal && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign bus.step      = r_step;
  assign bus.dir       = r_dir;
  assign bus.index     = r_index;
  assign bus.err       = r_err;
  assign bus.err_count = r_err_count;
  assign bus.a_f       = r_filt[0];
  assign bus.b_f       = r_filt[1];
  assign bus.z_f       = r_filt[2];

endmodule

// File: doc/quadrature_frontend.md
QUADRATURE_FRONTEND -- requirements
Module: quadrature_frontend

Interface
REQ-001 Parameter FILTER_LEN, default 4, glitch-filter length in clocks; legal range 1..15.
REQ-002 Parameter INDEX_GATE, default 1; when 1, index is qualified by filtered A=1 and B=1.
REQ-003 csi_MCLK_clk  input  1  sole clock; all state on rising edge.
REQ-004 rsi_MRST_reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 A  input  1  raw encoder channel A, asynchronous to clock.
REQ-006 B  input  1  raw encoder channel B, asynchronous to clock.
REQ-007 Z  input  1  raw encoder index, asynchronous to clock.
REQ-008 err_clear  input  1  synchronous single-cycle clear of err_count.
REQ-009 step  output  1  one-clock pulse per legal quadrature transition (4x decode).
REQ-010 dir  output  1  direction of the most recent step; 1 = forward (A leads B), 0 = reverse.
REQ-011 index  output  1  one-clock pulse on qualified rising edge of filtered Z.
REQ-012 err  output  1  one-clock pulse on illegal transition (A and B change together).
REQ-013 err_count  output  8  saturating count of illegal transitions.
REQ-014 a_f, b_f, z_f  output  1 each  filtered channel levels, for the downstream counter and for debug.

Function
REQ-015 Each of A, B, Z SHALL pass through a 2-flop synchronizer; the second flop output is the synced value.
REQ-016 Each channel SHALL have a 4-bit filter counter: synced != filtered -> counter+1; synced == filtered -> counter cleared to 0.
REQ-017 Filtered level SHALL toggle, and the counter SHALL clear, on the edge where the mismatch has been seen on FILTER_LEN consecutive edges; a shorter mismatch leaves the filtered level unchanged.
REQ-018 Decoder SHALL register the previous {a_f,b_f} and compare it with the current value every clock.
REQ-019 Forward sequence {A,B}: 00->10->11->01->00; reverse is the opposite order; either SHALL give step=1 for one clock, with dir updated on the same edge.
REQ-020 No change -> step=0, err=0, dir held.
REQ-021 Both bits changed -> err=1 for one clock, step=0, dir held, err_count+1.
REQ-022 err_count SHALL saturate at 255; further errors pulse err without incrementing.
REQ-023 err_clear=1 SHALL set err_count to 0 on the next edge; clear wins over a simultaneous error (result 0, err still pulses).
REQ-024 index SHALL pulse one clock when z_f goes 0->1 and (INDEX_GATE=0 or a_f=b_f=1 on that edge); index is independent of step and may coincide with it.
REQ-025 Latency: a clean input change that is stable across the first sampling edge (edge 1) SHALL produce step/err/index at rising edge FILTER_LEN+3.
REQ-026 step, err and index SHALL be registered outputs, each high for one clock only.
REQ-027 Sustained input rate above one transition per FILTER_LEN+1 clocks is out of spec; behaviour is defined only by REQ-016/017 (no lockup).

Reset
REQ-028 While rsi_MRST_reset_n=0: synchronizers, filter counters, filtered levels, previous-state register, step, dir, index, err and err_count SHALL all be 0.
REQ-029 Reset SHALL take effect immediately and asynchronously, including mid-filter or mid-sequence, and SHALL discard partial filter counts.
REQ-030 After deassertion, inputs already at A=B=1 SHALL filter up from 00 and produce a single err pulse (00->11) with no step.

Verification
REQ-031 FILTER_LEN=4: A 0->1 held, B=0 -> step=1 and dir=1 at edge 7 only; then B 0->1 -> second forward step.
REQ-032 FILTER_LEN=4: A high for 3 clocks then low -> a_f stays 0; no step or err.
REQ-033 Full reverse cycle 00->01->11->10->00 at 10-clock spacing -> 4 steps, dir=0 on each.
REQ-034 A and B toggle on the same clock 300 times, spaced 10 clocks -> 300 err pulses, err_count=255; err_clear -> 0; clear coinciding with an error -> 0.
REQ-035 INDEX_GATE=1: Z rises while a_f=b_f=1 -> one index pulse; Z rises while a_f=0 -> none.
REQ-036 Reset asserted mid-filter (counter=2) -> all outputs 0 at once; after release, same stable inputs take a full FILTER_LEN again.
